// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//   Registered WIDTH-bit add/subtract split into STAGES equal carry-chain
//   slices. There is one register rank per slice. The last rank drives the
//   outputs, so the latency is STAGES cycles when nothing stalls.
//
//   Subtraction is done as a + ~b + !carry_in. The raw carry travels down
//   the pipe, and only the final carry_out is inverted into a borrow.
//
//   Ports
//     c          clock (rising edge)
//     r          synchronous active-high reset
//     in_valid   operands valid          in_ready   operands accepted this cycle
//     sub        0 = add, 1 = subtract   carry_in   carry (add) / borrow (sub)
//     a, b       operands
//     out_valid  result valid            out_ready  downstream accepts result
//     sum        result                  carry_out  carry (add) / borrow (sub)
//     overflow   signed two's-complement overflow
// ---------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             c,
    input  logic             r,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    localparam int MSB  = WIDTH - 1;

    // Register ranks. Rank k holds the result bits of slices 0..k, the raw
    // carry out of slice k, and the operand bits still to be added.
    logic [STAGES-1:0]            r_v;
    logic [STAGES-1:0]            r_c;
    logic [STAGES-1:0]            r_sub;
    logic [STAGES-1:0][WIDTH-1:0] r_a;
    logic [STAGES-1:0][WIDTH-1:0] r_b;
    logic [STAGES-1:0][WIDTH-1:0] r_sum;
    logic                         r_cout;
    logic                         r_ovf;

    // Values each rank loads on the next advancing edge
    logic [STAGES-1:0]            w_v_next;
    logic [STAGES-1:0]            w_c_next;
    logic [STAGES-1:0]            w_sub_next;
    logic [STAGES-1:0][WIDTH-1:0] w_a_next;
    logic [STAGES-1:0][WIDTH-1:0] w_b_next;
    logic [STAGES-1:0][WIDTH-1:0] w_sum_next;
    logic                         w_cout_next;
    logic                         w_ovf_next;
    logic                         w_advance;

    // The pipe moves as a whole. An empty output slot or a consuming
    // downstream lets every rank shift, so bubbles are never collapsed.
    assign w_advance = !r_v[LAST] || out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SW{1'b1}}) << (gi * SW);

            logic             w_src_v;
            logic             w_src_c;
            logic             w_src_sub;
            logic [WIDTH-1:0] w_src_a;
            logic [WIDTH-1:0] w_src_b;
            logic [WIDTH-1:0] w_src_sum;
            logic [SW:0]      w_slice;

            if (gi == 0) begin : g_head
                // b and the carry are conditioned once at entry. Later
                // slices see a plain addition.
                assign w_src_v   = in_valid;
                assign w_src_sub = sub;
                assign w_src_a   = a;
                assign w_src_b   = sub ? ~b : b;
                assign w_src_c   = sub ? ~carry_in : carry_in;
                assign w_src_sum = '0;
            end else begin : g_body
                assign w_src_v   = r_v[gi-1];
                assign w_src_sub = r_sub[gi-1];
                assign w_src_a   = r_a[gi-1];
                assign w_src_b   = r_b[gi-1];
                assign w_src_c   = r_c[gi-1];
                assign w_src_sum = r_sum[gi-1];
            end

            assign w_slice = {1'b0, w_src_a[gi*SW +: SW]}
                           + {1'b0, w_src_b[gi*SW +: SW]}
                           + {{SW{1'b0}}, w_src_c};

            assign w_v_next[gi]   = w_src_v;
            assign w_c_next[gi]   = w_slice[SW];
            assign w_sub_next[gi] = w_src_sub;
            assign w_a_next[gi]   = w_src_a;
            assign w_b_next[gi]   = w_src_b;
            assign w_sum_next[gi] = (w_src_sum & ~SLICE_MASK)
                                  | (WIDTH'(w_slice[SW-1:0]) << (gi * SW));
        end
    endgenerate

    // The carry into the MSB equals a ^ b' ^ sum at that bit. Overflow
    // compares it with the raw carry out, before any borrow inversion.
    assign w_cout_next = w_c_next[LAST] ^ w_sub_next[LAST];
    assign w_ovf_next  = w_a_next[LAST][MSB] ^ w_b_next[LAST][MSB]
                       ^ w_sum_next[LAST][MSB] ^ w_c_next[LAST];

    always_ff @(posedge c) begin
        if (r) begin
            r_v    <= '0;
            r_c    <= '0;
            r_sub  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_advance) begin
            r_v    <= w_v_next;
            r_c    <= w_c_next;
            r_sub  <= w_sub_next;
            r_a    <= w_a_next;
            r_b    <= w_b_next;
            r_sum  <= w_sum_next;
            r_cout <= w_cout_next;
            r_ovf  <= w_ovf_next;
        end
    end

    // The final rank's operand and raw-carry copies are not needed, because
    // the flags are already folded into r_cout and r_ovf.
    logic w_unused;
    assign w_unused = ^{r_a[LAST], r_b[LAST], r_c[LAST], r_sub[LAST]};

    assign in_ready  = w_advance;
    assign out_valid = r_v[LAST];
    assign sum       = r_sum[LAST];
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder
//   Drives three instances (3/1, 8/2, 16/4) from shared stimulus. A
//   scoreboard per instance models the results with plain integer
//   arithmetic. It also checks latency, stall hold, handshake and reset.
// ---------------------------------------------------------------------------
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        sub_in;
    logic        cin;
    logic [15:0] a_in;
    logic [15:0] b_in;

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Instances
    logic       ir3, ov3, co3, of3;
    logic [2:0] s3;
    logic       ir8, ov8, co8, of8;
    logic [7:0] s8;
    logic        ir16, ov16, co16, of16;
    logic [15:0] s16;

    pipelined_adder #(.WIDTH(3), .STAGES(1)) u3 (
        .c(clk), .r(rst), .in_valid(in_valid), .in_ready(ir3), .sub(sub_in),
        .carry_in(cin), .a(a_in[2:0]), .b(b_in[2:0]), .out_valid(ov3),
        .out_ready(out_ready), .sum(s3), .carry_out(co3), .overflow(of3));

    pipelined_adder #(.WIDTH(8), .STAGES(2)) u8 (
        .c(clk), .r(rst), .in_valid(in_valid), .in_ready(ir8), .sub(sub_in),
        .carry_in(cin), .a(a_in[7:0]), .b(b_in[7:0]), .out_valid(ov8),
        .out_ready(out_ready), .sum(s8), .carry_out(co8), .overflow(of8));

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u16 (
        .c(clk), .r(rst), .in_valid(in_valid), .in_ready(ir16), .sub(sub_in),
        .carry_in(cin), .a(a_in), .b(b_in), .out_valid(ov16),
        .out_ready(out_ready), .sum(s16), .carry_out(co16), .overflow(of16));

    // Reference: {overflow, carry_out, sum[15:0]} from integer arithmetic
    function automatic logic [17:0] model(input int w, input logic [15:0] av,
                                          input logic [15:0] bv, input logic ci,
                                          input logic sb);
        longint m    = (64'sd1 <<< w) - 1;
        longint half = 64'sd1 <<< (w - 1);
        longint ua   = longint'(av) & m;
        longint ub   = longint'(bv) & m;
        longint sa   = (ua >= half) ? ua - (m + 1) : ua;
        longint sbv  = (ub >= half) ? ub - (m + 1) : ub;
        longint res;
        longint sres;
        logic   co;
        logic   of;
        if (!sb) begin
            res  = ua + ub + longint'(ci);
            co   = (res > m);
            sres = sa + sbv + longint'(ci);
        end else begin
            res  = ua - ub - longint'(ci);
            co   = (res < 0);
            sres = sa - sbv - longint'(ci);
        end
        of = (sres < -half) || (sres >= half);
        return {of, co, 16'(res & m)};
    endfunction

    // Scoreboard state per instance
    typedef struct {
        logic [17:0] exp;
        int          cyc;
        int          stl;
    } ent_t;

    ent_t        sb   [3][64];
    int          wp   [3] = '{0, 0, 0};
    int          rp   [3] = '{0, 0, 0};
    int          cyc  [3] = '{0, 0, 0};
    int          stall[3] = '{0, 0, 0};
    logic        rst_chk[3] = '{1'b0, 1'b0, 1'b0};
    logic        hold_v [3] = '{1'b0, 1'b0, 1'b0};
    logic [17:0] hold_d [3];

    task automatic mon(input int id, input int w, input int st,
                       input logic iv, input logic ir, input logic ov,
                       input logic orr, input logic rs,
                       input logic [15:0] av, input logic [15:0] bv,
                       input logic sb_i, input logic ci,
                       input logic [15:0] s, input logic co, input logic of);
        ent_t e;
        if (rst_chk[id]) begin
            check($sformatf("u%0d_rst_valid", id), 32'(ov), 0);
            check($sformatf("u%0d_rst_sum", id), 32'(s), 0);
            check($sformatf("u%0d_rst_flags", id), 32'({co, of}), 0);
            check($sformatf("u%0d_rst_ready", id), 32'(ir), 1);
            rst_chk[id] = 1'b0;
        end
        if (hold_v[id]) begin
            check($sformatf("u%0d_hold_valid", id), 32'(ov), 1);
            check($sformatf("u%0d_hold_data", id), 32'({of, co, s}), 32'(hold_d[id]));
            hold_v[id] = 1'b0;
        end
        check($sformatf("u%0d_in_ready", id), 32'(ir), 32'(!ov || orr));
        if (rs) begin
            rp[id]      = wp[id];
            rst_chk[id] = 1'b1;
        end else begin
            if (ov && orr) begin
                check($sformatf("u%0d_expected_out", id), 32'(wp[id] != rp[id]), 1);
                if (wp[id] != rp[id]) begin
                    e = sb[id][rp[id] % 64];
                    rp[id]++;
                    check($sformatf("u%0d_sum", id), 32'(s), 32'(e.exp[15:0]));
                    check($sformatf("u%0d_carry", id), 32'(co), 32'(e.exp[16]));
                    check($sformatf("u%0d_ovf", id), 32'(of), 32'(e.exp[17]));
                    check($sformatf("u%0d_latency", id), 32'(cyc[id] - e.cyc),
                          32'(st + stall[id] - e.stl));
                end
            end
            if (iv && ir) begin
                e.exp = model(w, av, bv, ci, sb_i);
                e.cyc = cyc[id];
                e.stl = stall[id];
                sb[id][wp[id] % 64] = e;
                wp[id]++;
            end
            if (ov && !orr) begin
                stall[id]++;
                hold_v[id] = 1'b1;
                hold_d[id] = {of, co, s};
            end
        end
        cyc[id]++;
    endtask

    always @(negedge clk) begin
        mon(0, 3, 1, in_valid, ir3, ov3, out_ready, rst, {13'b0, a_in[2:0]},
            {13'b0, b_in[2:0]}, sub_in, cin, {13'b0, s3}, co3, of3);
        mon(1, 8, 2, in_valid, ir8, ov8, out_ready, rst, {8'b0, a_in[7:0]},
            {8'b0, b_in[7:0]}, sub_in, cin, {8'b0, s8}, co8, of8);
        mon(2, 16, 4, in_valid, ir16, ov16, out_ready, rst, a_in, b_in,
            sub_in, cin, s16, co16, of16);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        a_in   = 16'($urandom);
        b_in   = 16'($urandom);
        cin    = 1'($urandom);
        sub_in = 1'($urandom);
    endtask

    // Directed 8-bit vectors: a, b, cin, sub, sum, carry_out, overflow
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sb;
        logic [7:0] s;
        logic       co;
        logic       of;
    } dir_t;

    dir_t dir_tab[6] = '{
        '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
        '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0},
        '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1},
        '{8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0},
        '{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0}
    };

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sub_in = 1'b0; cin = 1'b0; a_in = '0; b_in = '0;
        step(); step();
        rst = 1'b0;

        // Exhaustive 3-bit sweep, streaming
        for (int i = 0; i < 256; i++) begin
            a_in     = 16'(i & 7);
            b_in     = 16'((i >> 3) & 7);
            cin      = 1'((i >> 6) & 1);
            sub_in   = 1'((i >> 7) & 1);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();

        // Directed 8-bit boundaries, result two edges after acceptance
        for (int i = 0; i < 6; i++) begin
            a_in     = {8'h00, dir_tab[i].a};
            b_in     = {8'h00, dir_tab[i].b};
            cin      = dir_tab[i].ci;
            sub_in   = dir_tab[i].sb;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            check($sformatf("dir%0d_valid", i), 32'(ov8), 1);
            check($sformatf("dir%0d_sum", i), 32'(s8), 32'(dir_tab[i].s));
            check($sformatf("dir%0d_flags", i), 32'({co8, of8}),
                  32'({dir_tab[i].co, dir_tab[i].of}));
            repeat (4) step();
        end

        // Backpressure: out_ready pattern 1,0,0 while streaming
        for (int i = 0; i < 30; i++) begin
            rand_ops();
            in_valid  = 1'b1;
            out_ready = (i % 3 == 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) step();

        // Reset mid-flight: three pairs in, then reset with out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            in_valid = 1'b1;
            step();
        end
        rst = 1'b1;
        rand_ops();
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("u16_post_rst_valid", 32'(ov16), 0);
        check("u16_post_rst_sum", 32'(s16), 0);
        check("u16_post_rst_ready", 32'(ir16), 1);
        step();
        out_ready = 1'b1;
        rand_ops();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (6) step();

        // Reset while the full pipe is stalled
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rand_ops();
            in_valid = 1'b1;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) step();

        // Mode interleave at full throughput
        for (int i = 0; i < 100; i++) begin
            rand_ops();
            sub_in   = 1'(i & 1);
            in_valid = 1'b1;
            step();
        end

        // Random valid/ready mix
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) step();

        for (int id = 0; id < 3; id++)
            check($sformatf("u%0d_drained", id), 32'(wp[id] - rp[id]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
